// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, halt-state and ID/EX register types for the 16-bit core
package core_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        XOR    = 4'd2,
        RED    = 4'd3,
        SLL    = 4'd4,
        SRA    = 4'd5,
        ROR    = 4'd6,
        PADDSB = 4'd7,
        LW     = 4'd8,
        SW     = 4'd9,
        LLB    = 4'd10,
        LHB    = 4'd11,
        B      = 4'd12,
        BR     = 4'd13,
        PCS    = 4'd14,
        HLT    = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [3:0]        dst_reg;
        logic [3:0]        src_reg1;
        logic [3:0]        src_reg2;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc_plus2;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode decode: source selects, controls, immediate
module instr_decoder
    import core_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  src_reg1,
    output logic [3:0]  src_reg2,
    output logic [3:0]  dst_reg,
    output logic        use_src1,
    output logic        use_src2,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] imm
);

    opcode_e op;
    assign op = opcode_e'(instr[15:12]);

    always_comb begin
        src_reg1  = instr[7:4];
        src_reg2  = instr[3:0];
        use_src1  = 1'b0;
        use_src2  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        imm       = 16'h0000;
        case (op)
            ADD, SUB, XOR, RED, PADDSB: begin
                use_src1  = 1'b1;
                use_src2  = 1'b1;
                reg_write = 1'b1;
            end
            SLL, SRA, ROR: begin
                use_src1  = 1'b1;
                reg_write = 1'b1;
                imm       = {12'h000, instr[3:0]};
            end
            LW: begin
                use_src1  = 1'b1;
                reg_write = 1'b1;
                mem_read  = 1'b1;
                imm       = {{11{instr[3]}}, instr[3:0], 1'b0};
            end
            SW: begin
                src_reg2  = instr[11:8];
                use_src1  = 1'b1;
                use_src2  = 1'b1;
                mem_write = 1'b1;
                imm       = {{11{instr[3]}}, instr[3:0], 1'b0};
            end
            // LLB/LHB merge a byte into the old rd value, so rd is also read
            LLB, LHB: begin
                src_reg1  = instr[11:8];
                use_src1  = 1'b1;
                reg_write = 1'b1;
                imm       = {8'h00, instr[7:0]};
            end
            B: begin
                imm = {{6{instr[8]}}, instr[8:0], 1'b0};
            end
            BR: begin
                use_src1 = 1'b1;
            end
            PCS: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dst_reg = reg_write ? instr[11:8] : 4'h0;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, load-use interlock, flush bubble, HLT drain (option ID_STALL_CNT_EN)
module decode_stage
    import core_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_pc_plus2,
    input  logic              if_id_valid,
    input  logic              flush,
    input  logic              ex_stall,
    output logic [3:0]        rf_src_reg1,
    output logic [3:0]        rf_src_reg2,
    input  logic [DATA_W-1:0] rf_src_data1,
    input  logic [DATA_W-1:0] rf_src_data2,
    output logic              stall,
`ifdef ID_STALL_CNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic              id_ex_valid,
    output logic [3:0]        id_ex_opcode,
    output logic [3:0]        id_ex_dst_reg,
    output logic [3:0]        id_ex_src_reg1,
    output logic [3:0]        id_ex_src_reg2,
    output logic [DATA_W-1:0] id_ex_data1,
    output logic [DATA_W-1:0] id_ex_data2,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [DATA_W-1:0] id_ex_pc_plus2,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic              id_ex_mem_write,
    output logic              halted
);

    logic [3:0]  dec_dst;
    logic        dec_use1;
    logic        dec_use2;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic [15:0] dec_imm;

    instr_decoder u_dec (
        .instr     (if_id_instr),
        .src_reg1  (rf_src_reg1),
        .src_reg2  (rf_src_reg2),
        .dst_reg   (dec_dst),
        .use_src1  (dec_use1),
        .use_src2  (dec_use2),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .imm       (dec_imm)
    );

    id_ex_t      id_ex;
    id_ex_t      decoded;
    halt_state_e state;
    logic [7:0]  drain_cnt;
    logic        run;
    logic        hazard;
    logic        hlt_go;

    always_comb begin
        decoded           = ID_EX_BUBBLE;
        decoded.valid     = 1'b1;
        decoded.opcode    = if_id_instr[15:12];
        decoded.dst_reg   = dec_dst;
        decoded.src_reg1  = rf_src_reg1;
        decoded.src_reg2  = rf_src_reg2;
        decoded.data1     = rf_src_data1;
        decoded.data2     = rf_src_data2;
        decoded.imm       = dec_imm;
        decoded.pc_plus2  = if_id_pc_plus2;
        decoded.reg_write = dec_reg_write;
        decoded.mem_read  = dec_mem_read;
        decoded.mem_write = dec_mem_write;
    end

    assign run    = (state == RUN);
    assign hazard = if_id_valid && id_ex.valid && id_ex.mem_read && (id_ex.dst_reg != 4'h0) &&
                    ((dec_use1 && (id_ex.dst_reg == rf_src_reg1)) ||
                     (dec_use2 && (id_ex.dst_reg == rf_src_reg2)));
    // flush outranks the interlock: the waiting instruction is being discarded anyway
    assign stall  = !run || ex_stall || (hazard && !flush);
    assign hlt_go = run && if_id_valid && !ex_stall && !flush && !hazard &&
                    (if_id_instr[15:12] == HLT);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex     <= ID_EX_BUBBLE;
            state     <= RUN;
            drain_cnt <= 8'd0;
            halted    <= 1'b0;
        end else begin
            halted <= (state == HALTED);
            case (state)
                RUN: begin
                    if (!ex_stall) begin
                        if (flush || hazard || !if_id_valid)
                            id_ex <= ID_EX_BUBBLE;
                        else
                            id_ex <= decoded;
                    end
                    if (hlt_go) begin
                        state     <= DRAIN;
                        drain_cnt <= 8'd0;
                    end
                end
                DRAIN: begin
                    if (!ex_stall)
                        id_ex <= ID_EX_BUBBLE;
                    if (drain_cnt == 8'(DRAIN_CYC - 1))
                        state <= HALTED;
                    else
                        drain_cnt <= drain_cnt + 8'd1;
                end
                HALTED: begin
                    if (!ex_stall)
                        id_ex <= ID_EX_BUBBLE;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= 16'h0000;
        else if (run && (ex_stall || (hazard && !flush)) && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'h0001;
    end
`endif

    assign id_ex_valid     = id_ex.valid;
    assign id_ex_opcode    = id_ex.opcode;
    assign id_ex_dst_reg   = id_ex.dst_reg;
    assign id_ex_src_reg1  = id_ex.src_reg1;
    assign id_ex_src_reg2  = id_ex.src_reg2;
    assign id_ex_data1     = id_ex.data1;
    assign id_ex_data2     = id_ex.data2;
    assign id_ex_imm       = id_ex.imm;
    assign id_ex_pc_plus2  = id_ex.pc_plus2;
    assign id_ex_reg_write = id_ex.reg_write;
    assign id_ex_mem_read  = id_ex.mem_read;
    assign id_ex_mem_write = id_ex.mem_write;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (option ID_STALL_CNT_EN)
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        flush;
    logic        ex_stall;
    logic [3:0]  rf_src_reg1;
    logic [3:0]  rf_src_reg2;
    logic [15:0] rf_src_data1;
    logic [15:0] rf_src_data2;
    logic        stall;
    logic        id_ex_valid;
    logic [3:0]  id_ex_opcode;
    logic [3:0]  id_ex_dst_reg;
    logic [3:0]  id_ex_src_reg1;
    logic [3:0]  id_ex_src_reg2;
    logic [15:0] id_ex_data1;
    logic [15:0] id_ex_data2;
    logic [15:0] id_ex_imm;
    logic [15:0] id_ex_pc_plus2;
    logic        id_ex_reg_write;
    logic        id_ex_mem_read;
    logic        id_ex_mem_write;
    logic        halted;
`ifdef ID_STALL_CNT_EN
    logic [15:0] stall_count;
    logic [15:0] cnt_before;
`endif

    logic [15:0] rf [16];
    int checks;
    int errors;

    assign rf_src_data1 = rf[rf_src_reg1];
    assign rf_src_data2 = rf[rf_src_reg2];

    decode_stage dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus2  (if_id_pc_plus2),
        .if_id_valid     (if_id_valid),
        .flush           (flush),
        .ex_stall        (ex_stall),
        .rf_src_reg1     (rf_src_reg1),
        .rf_src_reg2     (rf_src_reg2),
        .rf_src_data1    (rf_src_data1),
        .rf_src_data2    (rf_src_data2),
        .stall           (stall),
`ifdef ID_STALL_CNT_EN
        .stall_count     (stall_count),
`endif
        .id_ex_valid     (id_ex_valid),
        .id_ex_opcode    (id_ex_opcode),
        .id_ex_dst_reg   (id_ex_dst_reg),
        .id_ex_src_reg1  (id_ex_src_reg1),
        .id_ex_src_reg2  (id_ex_src_reg2),
        .id_ex_data1     (id_ex_data1),
        .id_ex_data2     (id_ex_data2),
        .id_ex_imm       (id_ex_imm),
        .id_ex_pc_plus2  (id_ex_pc_plus2),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_mem_write (id_ex_mem_write),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h11);
        rf[0] = 16'h0000;
        rf[1] = 16'h0005;
        rf[2] = 16'h0007;
        rst = 1'b1;
        if_id_instr = 16'h0000;
        if_id_pc_plus2 = 16'h0000;
        if_id_valid = 1'b0;
        flush = 1'b0;
        ex_stall = 1'b0;
        step();
        step();
        check("rst_valid", id_ex_valid, 0);
        check("rst_opcode", id_ex_opcode, 0);
        check("rst_stall", stall, 0);
        check("rst_halted", halted, 0);
`ifdef ID_STALL_CNT_EN
        check("rst_cnt", stall_count, 0);
`endif
        rst = 1'b0;

        // ADD r3,r1,r2
        if_id_instr = 16'h0312; if_id_pc_plus2 = 16'h0102; if_id_valid = 1'b1;
        #1;
        check("add_rf1", rf_src_reg1, 1);
        check("add_rf2", rf_src_reg2, 2);
        check("add_stall", stall, 0);
        step();
        check("add_valid", id_ex_valid, 1);
        check("add_data1", id_ex_data1, 16'h0005);
        check("add_data2", id_ex_data2, 16'h0007);
        check("add_dst", id_ex_dst_reg, 3);
        check("add_rw", id_ex_reg_write, 1);
        check("add_pc", id_ex_pc_plus2, 16'h0102);
        check("add_imm", id_ex_imm, 0);

        // LLB r2,0x80 reads rd as source 1
        if_id_instr = 16'hA280;
        #1;
        check("llb_rf1", rf_src_reg1, 2);
        step();
        check("llb_imm", id_ex_imm, 16'h0080);
        check("llb_dst", id_ex_dst_reg, 2);
        check("llb_data1", id_ex_data1, 16'h0007);

        // B with imm9 = -1
        if_id_instr = 16'hC1FF;
        step();
        check("b_imm", id_ex_imm, 16'hFFFE);
        check("b_rw", id_ex_reg_write, 0);

        // LW r4,0(r1) then ADD r5,r4,r2
        if_id_instr = 16'h8410;
        step();
        check("lw_mr", id_ex_mem_read, 1);
        check("lw_dst", id_ex_dst_reg, 4);
        if_id_instr = 16'h0542;
        #1;
        check("lu_stall", stall, 1);
        step();
        check("lu_bubble", id_ex_valid, 0);
        check("lu_bubble_rw", id_ex_reg_write, 0);
        check("lu_stall_off", stall, 0);
        step();
        check("lu_add_valid", id_ex_valid, 1);
        check("lu_add_dst", id_ex_dst_reg, 5);
        check("lu_add_data1", id_ex_data1, 16'h0044);

        // LW r0 then ADD r5,r0,r2: no interlock
        if_id_instr = 16'h8010;
        step();
        if_id_instr = 16'h0502;
        #1;
        check("lw_r0_stall", stall, 0);
        step();
        check("lw_r0_valid", id_ex_valid, 1);

        // flush SUB r7,r1,r2
        if_id_instr = 16'h1712; flush = 1'b1;
        step();
        check("flush_valid", id_ex_valid, 0);
        flush = 1'b0;
        if_id_instr = 16'h8410;
        step();
        if_id_instr = 16'h0542; flush = 1'b1;
        #1;
        check("flush_lu_stall", stall, 0);
        step();
        check("flush_lu_valid", id_ex_valid, 0);
        flush = 1'b0; if_id_valid = 1'b0;
        step();

        // SW r6,2(r1) held by ex_stall
        if_id_instr = 16'h9612; if_id_valid = 1'b1;
        step();
        check("sw_imm", id_ex_imm, 16'h0004);
        check("sw_data2", id_ex_data2, 16'h0066);
        check("sw_mw", id_ex_mem_write, 1);
        if_id_valid = 1'b0; ex_stall = 1'b1;
`ifdef ID_STALL_CNT_EN
        cnt_before = stall_count;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            check("exs_stall", stall, 1);
            step();
            check("exs_valid", id_ex_valid, 1);
            check("exs_imm", id_ex_imm, 16'h0004);
            check("exs_data2", id_ex_data2, 16'h0066);
        end
        ex_stall = 1'b0;
`ifdef ID_STALL_CNT_EN
        check("cnt_delta", 32'(stall_count - cnt_before), 3);
        check("cnt_total", stall_count, 4);
`endif
        step();
        check("exs_release", id_ex_valid, 0);

        // HLT with flush stays in RUN
        rst = 1'b1; step(); rst = 1'b0;
        if_id_instr = 16'hF000; if_id_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; if_id_valid = 1'b0;
        #1;
        check("hlt_flush_stall", stall, 0);
        check("hlt_flush_valid", id_ex_valid, 0);

        // HLT drain
        if_id_valid = 1'b1;
        step();
        check("hlt_opcode", id_ex_opcode, 15);
        check("hlt_valid", id_ex_valid, 1);
        check("hlt_stall", stall, 1);
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("drain_halted", halted, 0);
            check("drain_valid", id_ex_valid, 0);
            check("drain_stall", stall, 1);
        end
        step();
        check("halted", halted, 1);
        check("halted_stall", stall, 1);
        flush = 1'b0;
        step();
        check("halted_hold", halted, 1);

        // reset mid-drain
        rst = 1'b1; step(); rst = 1'b0;
        if_id_valid = 1'b1;
        step();
        if_id_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_drain_halted", halted, 0);
        check("rst_drain_stall", stall, 0);
        step();
        step();
        step();
        check("rst_drain_after", halted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
